led_fader: RTL and testbench
============================

Name: led_fader

Overview:
- Downstream stage of the LED pattern sequencer: consumes its N-bit LED pattern and drives the physical LED pins.
- Each channel turns on at full brightness immediately when its pattern bit is set.
- When the bit clears, the channel fades out linearly under PWM, giving a trailing-glow effect.
- Sits between the pattern FSM and the board pins, in the same clock domain as the sequencer.

Parameters:
- N, 8, number of LED channels (width of leds_in/pwm_out).
- PW, 4, brightness resolution in bits; MAX = 2^PW-1 = 15.
- FADE_DIV, 16, clock cycles per one-step brightness decrement (≥2).

Ports:
- ck  in  1  system clock, rising edge.
- rs_n  in  1  reset, asynchronous, active-low.
- en  in  1  run enable; 0 freezes fade state and blanks outputs.
- leds_in  in  N  LED pattern from the sequencer, sampled every ck edge.
- pwm_out  out  N  registered PWM drive per LED, 1 = lit.
- busy  out  1  1 while any channel level is strictly between 0 and MAX.

Behaviour:
- Reset (rs_n=0, immediate, no clock needed): pwm_cnt=0, div_cnt=0, all level[i]=0, pwm_out=0, busy=0.
- pwm_cnt: PW bits; counts 0..MAX-1 and wraps to 0 (PWM period = MAX = 15 cycles); advances only when en=1.
- div_cnt: counts 0..FADE_DIV-1 and wraps; advances only when en=1.
- fade_tick = en & (div_cnt==FADE_DIV-1), asserted in the cycle the counter wraps; exactly one tick per FADE_DIV enabled cycles.
- Per-channel level[i] (PW bits), updated on each edge while en=1:
  - leds_in[i]=1 -> level[i] <= MAX (instant attack, independent of fade_tick).
  - leds_in[i]=0 and fade_tick -> level[i] <= level[i]-1, saturating at 0.
  - otherwise level[i] holds.
- Simultaneous leds_in[i]=1 and fade_tick: set wins; level goes to MAX.
- Output: pwm_out[i] <= en & (level[i] > pwm_cnt), one register stage.
  - level MAX -> always lit; level 0 -> always dark.
  - level L -> exactly L high cycles per 15-cycle window.
- Latency: leds_in[i] rise at edge k -> level=MAX after edge k -> pwm_out[i]=1 after edge k+1.
- en=0:
  - pwm_cnt, div_cnt and levels hold.
  - leds_in is ignored.
  - pwm_out goes 0 at the next edge.
  - en returning to 1 resumes from the held state; no tick is lost or duplicated.
- busy is combinational from the level registers (OR over i of 0<level[i]<MAX); it does not depend on en.
- Async reset mid-fade clears all state; the first enabled edge after rs_n rises behaves as cycle 0.

Decomposition:
- Shared package led_pkg: default PW, derived MAX constant, default FADE_DIV.
- Sub-module led_fade_ch: one channel (level register, set/decay logic, comparator, output flop). Instantiated N times via generate.
- pwm_cnt and div_cnt live in the top level and are shared by all channels.

Test Plan:
- Reset: hold rs_n=0 mid-run with leds_in=0xFF -> pwm_out=0x00 and busy=0 with no clock edge; release with leds_in=0x00 for 100 cycles -> pwm_out stays 0x00.
- Attack: leds_in=0x01 at edge k -> pwm_out[0]=1 from edge k+1 onward, continuously; pwm_out[7:1]=0; busy=0 throughout.
- Decay: after level[0]=15, drive leds_in=0x00 -> level[0] decrements once per 16 cycles and reaches 0 after exactly 15 ticks; busy=1 until then.
  - Duty check at level 10: 10 high cycles per 15-cycle window.
  - Duty check at level 1: 1 high cycle per window.
- Collision: with level[0]=7, assert leds_in[0]=1 in the same cycle as fade_tick -> level[0]=15, not 6; pwm_out[0] solid high.
- Sequencer stimulus: leds_in steps 0x01,0x03,…,0xFF,0x01, holding each value 64 cycles.
  - Channels 0..i are solid high as their bits set.
  - 64 cycles after the 0xFF->0x01 step, level[7:1]=11 each, busy=1, pwm_out[0] solid high.
- Enable freeze: en=0 mid-fade at level 9 -> pwm_out=0x00 next edge; level stays 9 for 100 cycles; after en=1, the next decrement occurs after the remaining prescaler count.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared constants for the LED fader. It holds the default
//                brightness resolution, the derived full-brightness level
//                and the default fade prescaler.
//  Revision    : 1.0  initial release
// ============================================================================
package led_pkg;

  // default brightness resolution in bits
  localparam int c_pw       = 4;
  // full brightness level, 2^PW-1
  localparam int c_max      = (1 << c_pw) - 1;
  // default number of clock cycles per one-step brightness decrement
  localparam int c_fade_div = 16;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_fade_ch.sv
`default_nettype none
// ============================================================================
//  Module      : led_fade_ch
//  Description : One LED channel. It holds the brightness level register.
//                A set pattern bit loads full brightness, and each fade tick
//                decays the level when the bit is clear. A comparator against
//                the shared PWM counter feeds a registered output.
//  Ports       : ck         - system clock, rising edge
//                rs_n       - asynchronous active-low reset
//                i_en       - run enable (0 holds the level, blanks output)
//                i_fade_tick- one-cycle decay strobe from the prescaler
//                i_led      - pattern bit for this channel
//                i_pwm_cnt  - shared PWM phase counter
//                o_pwm      - registered PWM drive, 1 = lit
//                o_busy     - level strictly between 0 and full brightness
//  Revision    : 1.0  initial release
// ============================================================================
module led_fade_ch #(
  parameter int PW = 4
) (
  input  logic          ck,
  input  logic          rs_n,
  input  logic          i_en,
  input  logic          i_fade_tick,
  input  logic          i_led,
  input  logic [PW-1:0] i_pwm_cnt,
  output logic          o_pwm,
  output logic          o_busy
);

  localparam logic [PW-1:0] c_max  = {PW{1'b1}};
  localparam logic [PW-1:0] c_zero = '0;

  logic [PW-1:0] r_level;
  logic          r_pwm;

  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n) begin
      r_level <= c_zero;
      r_pwm   <= 1'b0;
    end else begin
      // Compare uses the pre-update level, so a new attack shows on the
      // pins one edge after the level register loads.
      r_pwm <= i_en & (r_level > i_pwm_cnt);
      if (i_en) begin
        // A set bit outranks a coincident fade tick.
        if (i_led) begin
          r_level <= c_max;
        end else if (i_fade_tick && (r_level != c_zero)) begin
          r_level <= r_level - 1'b1;
        end
      end
    end
  end

  assign o_pwm  = r_pwm;
  assign o_busy = (r_level != c_zero) && (r_level != c_max);

endmodule : led_fade_ch
`default_nettype wire

// File: rtl/led_fader.sv
`default_nettype none
// ============================================================================
//  Module      : led_fader
//  Description : LED pin driver placed after the pattern sequencer. A channel
//                lights at full brightness as soon as its pattern bit sets.
//                When the bit clears, the channel fades out linearly under
//                PWM. The PWM phase counter and the fade prescaler are shared
//                by all channels.
//  Ports       : ck       - system clock, rising edge
//                rs_n     - asynchronous active-low reset
//                en       - run enable; 0 freezes all state, blanks outputs
//                leds_in  - N-bit LED pattern, sampled every edge
//                pwm_out  - registered PWM drive per LED, 1 = lit
//                busy     - some channel is partway through a fade
//  Revision    : 1.0  initial release
// ============================================================================
module led_fader
  import led_pkg::*;
#(
  parameter int N        = 8,
  parameter int PW       = c_pw,
  parameter int FADE_DIV = c_fade_div
) (
  input  logic         ck,
  input  logic         rs_n,
  input  logic         en,
  input  logic [N-1:0] leds_in,
  output logic [N-1:0] pwm_out,
  output logic         busy
);

  localparam int            DW         = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
  localparam logic [PW-1:0] c_max      = {PW{1'b1}};
  // The PWM period is MAX cycles, not 2^PW. This lets level MAX stay lit
  // continuously while level 0 stays dark.
  localparam logic [PW-1:0] c_pwm_last = c_max - 1'b1;
  localparam logic [DW-1:0] c_div_last = DW'(FADE_DIV - 1);

  logic [PW-1:0] r_pwm_cnt;
  logic [DW-1:0] r_div_cnt;
  logic          w_fade_tick;
  logic [N-1:0]  w_ch_busy;

  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n) begin
      r_pwm_cnt <= '0;
      r_div_cnt <= '0;
    end else if (en) begin
      r_pwm_cnt <= (r_pwm_cnt == c_pwm_last) ? '0 : r_pwm_cnt + 1'b1;
      r_div_cnt <= (r_div_cnt == c_div_last) ? '0 : r_div_cnt + 1'b1;
    end
  end

  // Qualified by en so a frozen prescaler sitting on its last count does not
  // tick on every disabled cycle.
  assign w_fade_tick = en & (r_div_cnt == c_div_last);

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    led_fade_ch #(
      .PW (PW)
    ) u_ch (
      .ck          (ck),
      .rs_n        (rs_n),
      .i_en        (en),
      .i_fade_tick (w_fade_tick),
      .i_led       (leds_in[gi]),
      .i_pwm_cnt   (r_pwm_cnt),
      .o_pwm       (pwm_out[gi]),
      .o_busy      (w_ch_busy[gi])
    );
  end

  assign busy = |w_ch_busy;

endmodule : led_fader
`default_nettype wire

// File: tb/tb_led_fader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_fader
//  Description : Self-checking bench for led_fader. A reference model keeps
//                per-channel brightness as integers and derives the PWM phase
//                and fade ticks from a count of enabled cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_fader;

  localparam int N   = 8;
  localparam int MAX = 15;
  localparam int DIV = 16;

  logic         ck;
  logic         rs_n;
  logic         en;
  logic [N-1:0] leds_in;
  logic [N-1:0] pwm_out;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  led_fader #(.N(N), .PW(4), .FADE_DIV(DIV)) dut (
    .ck      (ck),
    .rs_n    (rs_n),
    .en      (en),
    .leds_in (leds_in),
    .pwm_out (pwm_out),
    .busy    (busy)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. ecnt counts enabled edges since reset. The PWM phase is
  // ecnt mod 15, and a fade tick falls on every 16th enabled edge.
  int           lvl [N];
  int           ecnt;
  logic [N-1:0] exp_pwm;

  always @(posedge ck or negedge rs_n) begin
    if (!rs_n) begin
      ecnt    <= 0;
      exp_pwm <= '0;
      for (int i = 0; i < N; i++) lvl[i] <= 0;
    end else if (en) begin
      for (int i = 0; i < N; i++) begin
        exp_pwm[i] <= (lvl[i] > (ecnt % MAX));
        if (leds_in[i])                             lvl[i] <= MAX;
        else if ((ecnt % DIV) == DIV - 1 && lvl[i] > 0) lvl[i] <= lvl[i] - 1;
      end
      ecnt <= ecnt + 1;
    end else begin
      exp_pwm <= '0;
    end
  end

  function automatic logic model_busy();
    logic b = 1'b0;
    for (int i = 0; i < N; i++) if (lvl[i] > 0 && lvl[i] < MAX) b = 1'b1;
    return b;
  endfunction

  // Every-cycle comparison, taken 1 time unit after the clock edge.
  always @(posedge ck) begin
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    chk("busy",    32'(busy),    32'(model_busy()));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge ck);
  endtask

  // Counts lit cycles of channel 0 over one 15-cycle window.
  task automatic duty0(output int c);
    c = 0;
    repeat (MAX) begin
      @(posedge ck);
      #1;
      c += int'(pwm_out[0]);
    end
    @(negedge ck);
  endtask

  // Waits at negedges until model level of channel 0 equals target.
  task automatic wait_lvl0(input int target, input bit need_tick, input string tag);
    int k = 0;
    while (!(lvl[0] == target && (!need_tick || (ecnt % DIV) == DIV - 1)) && k < 2000) begin
      @(negedge ck);
      k++;
    end
    if (k >= 2000) chk({tag, "_timeout"}, 32'(lvl[0]), 32'(target));
  endtask

  int c;
  logic [N-1:0] pat;

  initial begin
    rs_n    = 1'b0;
    en      = 1'b0;
    leds_in = '0;
    cycles(3);
    chk("reset_pwm", 32'(pwm_out), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rs_n = 1'b1;
    en   = 1'b1;

    // Attack: channel 0 lit from the edge after the level loads.
    leds_in = 8'h01;
    cycles(40);
    chk("attack_pwm", 32'(pwm_out), 32'h01);
    chk("attack_busy", 32'(busy), 32'h0);

    // Decay with duty checks at level 10 and level 1.
    leds_in = 8'h00;
    wait_lvl0(10, 1'b0, "wait10");
    duty0(c);
    chk("duty_lvl10", 32'(c), 32'd10);
    chk("busy_fade", 32'(busy), 32'h1);
    wait_lvl0(1, 1'b0, "wait1");
    duty0(c);
    chk("duty_lvl1", 32'(c), 32'd1);
    wait_lvl0(0, 1'b0, "wait0");
    cycles(2);
    chk("decay_done_busy", 32'(busy), 32'h0);
    chk("decay_done_pwm", 32'(pwm_out), 32'h0);

    // Collision: set coincides with a fade tick at level 7.
    leds_in = 8'h01;
    cycles(3);
    leds_in = 8'h00;
    wait_lvl0(7, 1'b1, "wait7");
    leds_in = 8'h01;
    @(negedge ck);
    leds_in = 8'h00;
    chk("collision_busy", 32'(busy), 32'h0);
    duty0(c);
    chk("collision_duty", 32'(c), 32'd15);

    // Enable freeze at level 9.
    wait_lvl0(9, 1'b0, "wait9");
    cycles(5);
    en = 1'b0;
    cycles(100);
    chk("freeze_pwm", 32'(pwm_out), 32'h0);
    chk("freeze_busy", 32'(busy), 32'h1);
    en = 1'b1;
    wait_lvl0(8, 1'b0, "wait8");
    duty0(c);
    chk("resume_duty", 32'(c), 32'd8);

    // Sequencer walk 0x01..0xFF then back to 0x01.
    pat = 8'h01;
    for (int s = 0; s < N; s++) begin
      leds_in = pat;
      cycles(64);
      chk("seq_solid", 32'(pwm_out), 32'(pat));
      pat = {pat[N-2:0], 1'b1};
    end
    leds_in = 8'h01;
    cycles(64);
    chk("seq_tail_busy", 32'(busy), 32'h1);
    chk("seq_tail_ch0", 32'(pwm_out[0]), 32'h1);

    // Asynchronous reset mid-fade with all bits set.
    leds_in = 8'hFF;
    #2;
    rs_n = 1'b0;
    #1;
    chk("async_rst_pwm", 32'(pwm_out), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    cycles(3);
    leds_in = 8'h00;
    rs_n    = 1'b1;
    cycles(100);
    chk("post_rst_pwm", 32'(pwm_out), 32'h0);

    // Randomized segments with enable gaps and occasional resets.
    for (int seg = 0; seg < 60; seg++) begin
      leds_in = N'($urandom & $urandom & $urandom);
      en      = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 15) == 0) begin
        #3;
        rs_n = 1'b0;
        @(negedge ck);
        rs_n = 1'b1;
      end
      cycles($urandom_range(1, 60));
      if ($urandom_range(0, 2) == 0) begin
        leds_in = '0;
        en      = 1'b1;
        cycles($urandom_range(20, 120));
      end
    end

    cycles(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_led_fader
`default_nettype wire
